// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and decode helpers for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  typedef logic [3:0] key_code_t;

  localparam logic [3:0] COL_NONE  = 4'b1111;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Lowest-index active-low column wins when several are down.
  function automatic logic [1:0] first_col(input logic [3:0] col);
    if (!col[0]) begin
      return 2'd0;
    end else if (!col[1]) begin
      return 2'd1;
    end else if (!col[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all ones (idle pulled-up lines)
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with debounce and valid/ack output
// Define KEYPAD_REPEAT_EN to add auto-repeat events while a key stays down.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 134999,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row_sel,
  input  logic [3:0] col_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam logic [27:0] DIV_LAST   = 28'(SCAN_DIV);
  localparam logic [4:0]  DEB_TARGET = 5'(DEBOUNCE_SCANS);
  localparam bit          DEB_ONE    = (DEBOUNCE_SCANS == 1);

  logic [3:0] col_s;

  sync_2ff #(.WIDTH(4)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (col_in),
    .q_o   (col_s)
  );

  logic [27:0] tick_cnt_q;
  logic [27:0] tick_cnt_d;
  logic        tick;

  always_comb begin
    tick       = (tick_cnt_q == DIV_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 28'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  kp_state_e  state_q;
  logic [1:0] row_q;
  logic [3:0] row_sel_q;
  key_code_t  cand_q;
  logic [3:0] deb_cnt_q;
  key_code_t  key_code_q;
  logic       key_valid_q;
  logic       key_held_q;
  logic       overrun_q;

  logic       col_none;
  key_code_t  cur_code;
  logic       cand_seen;
  logic [4:0] deb_next;
  logic       deb_done;
  logic       rep_hit;
  logic       emit;
  key_code_t  emit_code;

  always_comb begin
    col_none  = (col_s == COL_NONE);
    cur_code  = {row_q, first_col(col_s)};
    cand_seen = !col_none && (cur_code == cand_q);
    deb_next  = {1'b0, deb_cnt_q} + 5'd1;
    deb_done  = (deb_next >= DEB_TARGET);
    // A single-scan debounce emits straight out of SCAN, before cand_q is loaded.
    emit_code = (state_q == ST_SCAN) ? cur_code : cand_q;
    emit      = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN:     emit = !col_none && DEB_ONE;
        ST_DEBOUNCE: emit = cand_seen && deb_done;
        ST_PRESSED:  emit = rep_hit;
        default:     emit = 1'b0;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_TARGET = 16'(REPEAT_SCANS);

  logic [15:0] rep_cnt_q;
  logic [15:0] rep_next;

  assign rep_next = rep_cnt_q + 16'd1;
  assign rep_hit  = !col_none && (rep_next == REP_TARGET);

  // Held at zero outside PRESSED, so every entry starts a fresh repeat period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_cnt_q <= '0;
    end else if (tick) begin
      if (state_q != ST_PRESSED) begin
        rep_cnt_q <= '0;
      end else if (!col_none) begin
        rep_cnt_q <= rep_hit ? '0 : rep_next;
      end
    end
  end
`else
  logic unused_repeat;
  assign rep_hit       = 1'b0;
  assign unused_repeat = ^32'(REPEAT_SCANS);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      row_q       <= 2'd0;
      row_sel_q   <= ROW_RESET;
      cand_q      <= '0;
      deb_cnt_q   <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (tick) begin
        unique case (state_q)
          ST_SCAN: begin
            if (col_none) begin
              row_q     <= row_q + 2'd1;
              row_sel_q <= row_drive(row_q + 2'd1);
            end else begin
              cand_q    <= cur_code;
              deb_cnt_q <= 4'd1;
              if (DEB_ONE) begin
                state_q    <= ST_PRESSED;
                key_held_q <= 1'b1;
              end else begin
                state_q <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (cand_seen) begin
              deb_cnt_q <= deb_next[3:0];
              if (deb_done) begin
                state_q    <= ST_PRESSED;
                key_held_q <= 1'b1;
              end
            end else begin
              row_q     <= row_q + 2'd1;
              row_sel_q <= row_drive(row_q + 2'd1);
              state_q   <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            if (col_none) begin
              deb_cnt_q <= 4'd1;
              state_q   <= ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (col_none) begin
              deb_cnt_q <= deb_next[3:0];
              if (deb_done) begin
                key_held_q <= 1'b0;
                row_q      <= row_q + 2'd1;
                row_sel_q  <= row_drive(row_q + 2'd1);
                state_q    <= ST_SCAN;
              end
            end else if (cand_seen) begin
              state_q <= ST_PRESSED;
            end
          end
          default: state_q <= ST_SCAN;
        endcase
      end

      if (emit) begin
        if (!key_valid_q || key_ack) begin
          key_code_q  <= emit_code;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_ack) begin
        key_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
    end
  end

  assign row_sel   = row_sel_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - keypad_scan bench: physical keypad model plus tick-level reference
module tb_keypad_scan;

  localparam int DS = 2;
  localparam int RS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_sel;
  logic [3:0] col_in = 4'b1111;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;

  always #5 clk = ~clk;

  keypad_scan #(
    .SCAN_DIV       (3),
    .DEBOUNCE_SCANS (DS),
    .REPEAT_SCANS   (RS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_sel   (row_sel),
    .col_in    (col_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit pressed[16];

  // Reference: mode 0 hunting, 1 confirming a press, 2 down, 3 confirming a release.
  int n_m, row_m, mode_m, cand_m, streak_m, rep_m, exp_code;
  bit exp_valid, exp_held, exp_over;

  function automatic int visible(input int r);
    for (int c = 0; c < 4; c++) begin
      if (pressed[r*4 + c]) return c;
    end
    return -1;
  endfunction

  task automatic update_cols();
    logic [3:0] v;
    v = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (row_sel[r] === 1'b0 && pressed[r*4 + c]) v[c] = 1'b0;
      end
    end
    col_in = v;
  endtask

  task automatic set_key(input int k, input bit v);
    pressed[k] = v;
    update_cols();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    n_m = 0; row_m = 0; mode_m = 0; cand_m = 0; streak_m = 0; rep_m = 0;
    exp_code = 0; exp_valid = 0; exp_held = 0; exp_over = 0;
  endtask

  task automatic model_edge(input bit ack_s);
    bit emit;
    int vis, code;
    emit = 0;
    n_m++;
    if (n_m % 4 == 0) begin
      vis  = visible(row_m);
      code = (vis < 0) ? -1 : row_m*4 + vis;
      case (mode_m)
        0: if (vis < 0) row_m = (row_m + 1) % 4;
           else begin
             cand_m = code; streak_m = 1;
             if (DS == 1) begin mode_m = 2; emit = 1; exp_held = 1; rep_m = 0; end
             else mode_m = 1;
           end
        1: if (code == cand_m) begin
             streak_m++;
             if (streak_m >= DS) begin mode_m = 2; emit = 1; exp_held = 1; rep_m = 0; end
           end else begin
             row_m = (row_m + 1) % 4; mode_m = 0;
           end
        2: if (vis < 0) begin streak_m = 1; mode_m = 3; end
`ifdef KEYPAD_REPEAT_EN
           else begin
             rep_m++;
             if (rep_m == RS) begin emit = 1; rep_m = 0; end
           end
`endif
        default: if (vis < 0) begin
             streak_m++;
             if (streak_m >= DS) begin exp_held = 0; row_m = (row_m + 1) % 4; mode_m = 0; end
           end else if (code == cand_m) begin
             mode_m = 2; rep_m = 0;
           end
      endcase
    end
    if (emit) begin
      if (!exp_valid || ack_s) begin exp_code = cand_m; exp_valid = 1; end
      else exp_over = 1;
    end else if (exp_valid && ack_s) begin
      exp_valid = 0; exp_over = 0;
    end
  endtask

  task automatic check_all();
    chk("row_sel", row_sel, 4'b1111 ^ (4'b0001 << row_m));
    chk("key_valid", {3'b0, key_valid}, {3'b0, exp_valid});
    chk("key_code", key_code, 4'(exp_code));
    chk("key_held", {3'b0, key_held}, {3'b0, exp_held});
    chk("overrun", {3'b0, overrun}, {3'b0, exp_over});
  endtask

  task automatic step();
    bit a;
    a = key_ack;
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(a);
    #1;
    update_cols();
    check_all();
  endtask

  task automatic to_tick();
    for (int i = 0; i < 8; i++) begin
      step();
      if (n_m % 4 == 0) break;
    end
  endtask

  function automatic bit cond(input int kind);
    case (kind)
      0: return key_valid === 1'b1;
      1: return key_held === 1'b1;
      2: return key_held === 1'b0;
      3: return mode_m == 1 && (n_m % 4) == 3;
      4: return mode_m == 0 && row_m == 3 && (n_m % 4) == 0;
      default: return mode_m == 1;
    endcase
  endfunction

  task automatic wait_for(input int kind, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (cond(kind)) begin ok = 1; break; end
      step();
    end
    n_assert++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL wait_%s: condition not reached within 200 clocks (observed 0 required 1)", tag);
    end
  endtask

  task automatic tap_key(input int k);
    to_tick();
    set_key(k, 1);
    wait_for(1, "held");
    to_tick();
    set_key(k, 0);
    wait_for(2, "release");
  endtask

  task automatic rand_ticks(input int n);
    repeat (n * 4) begin
      key_ack = ($urandom_range(0, 5) == 0);
      step();
    end
    key_ack = 1'b0;
  endtask

  initial begin
    model_reset();
    update_cols();
    reset = 1'b0;
    step();
    step();
    chk("rst_row_sel", row_sel, 4'b1110);
    chk("rst_key_code", key_code, 4'h0);
    chk("rst_flags", {key_valid, key_held, overrun, 1'b0}, 4'b0000);
    reset = 1'b1;

    // Idle scan: one row per 4-clock tick period.
    repeat (4) step();
    chk("idle_row1", row_sel, 4'b1101);
    repeat (12) step();
    chk("idle_wrap", row_sel, 4'b1110);

    // Key 6 (row 1, col 2), then a single ack pulse.
    set_key(6, 1);
    wait_for(0, "valid6");
    chk("code6", key_code, 4'h6);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("ack_clears", {3'b0, key_valid}, 4'h0);
    to_tick();
    set_key(6, 0);
    wait_for(2, "rel6");

    // One-tick glitch on key 12 (row 3, col 0).
    wait_for(4, "row3");
    set_key(12, 1);
    repeat (4) step();
    set_key(12, 0);
    repeat (4) step();
    chk("glitch_valid", {3'b0, key_valid}, 4'h0);
    chk("glitch_row", row_sel, 4'b1110);

    // Two presses without ack: first code kept, overrun set.
    tap_key(5);
    tap_key(9);
    chk("ovr_code", key_code, 4'h5);
    chk("ovr_flag", {3'b0, overrun}, 4'h1);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("ovr_ack", {2'b0, key_valid, overrun}, 4'h0);

    // Ack in the same cycle as a new event.
    tap_key(3);
    to_tick();
    set_key(10, 1);
    wait_for(3, "pre_emit");
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("same_cyc_valid", {3'b0, key_valid}, 4'h1);
    chk("same_cyc_code", key_code, 4'hA);
    chk("same_cyc_ovr", {3'b0, overrun}, 4'h0);
    to_tick();
    set_key(10, 0);
    wait_for(2, "rel10");

    // Reset mid-debounce with an event still pending.
    to_tick();
    set_key(7, 1);
    wait_for(5, "debounce");
    reset = 1'b0;
    step();
    chk("mid_rst_row", row_sel, 4'b1110);
    chk("mid_rst_code", key_code, 4'h0);
    chk("mid_rst_flags", {key_valid, key_held, overrun, 1'b0}, 4'b0000);
    reset = 1'b1;
    set_key(7, 0);
    repeat (8) step();

`ifdef KEYPAD_REPEAT_EN
    to_tick();
    set_key(15, 1);
    for (int e = 0; e < 3; e++) begin
      wait_for(0, "repeat");
      chk("repeat_code", key_code, 4'hF);
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
    end
    to_tick();
    set_key(15, 0);
    wait_for(2, "rel15");
`endif

    // Random presses, occasional second key, random acks.
    to_tick();
    for (int it = 0; it < 40; it++) begin
      int k1, k2;
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      set_key(k1, 1);
      if ($urandom_range(0, 3) == 0) set_key(k2, 1);
      rand_ticks($urandom_range(1, 6));
      for (int k = 0; k < 16; k++) pressed[k] = 0;
      update_cols();
      rand_ticks($urandom_range(1, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Row-scanned 4x4 matrix keypad reader: the input-side counterpart of the multiplexed FND display driver. It drives one keypad row low at a time and samples the four column lines. It debounces the first pressed key and presents a 4-bit key code to the application logic through a valid/ack handshake. It sits beside the FND driver on the board-I/O boundary and shares its scan-rate divider scheme.

## Interface
- SCAN_DIV, 134999: a scan tick fires every SCAN_DIV+1 clocks; one row is held for one tick period.
- DEBOUNCE_SCANS, 4: consecutive identical ticks required to accept a press or a release; range 1..15.
- REPEAT_SCANS, 64: ticks between auto-repeat events; only used with KEYPAD_REPEAT_EN.
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- row_sel  output  4  one-hot-low row drive; bit r low means row r is driven
- col_in  input  4  column lines, active-low, externally pulled up, asynchronous
- key_code  output  4  {row[1:0], col[1:0]}, i.e. row*4+col
- key_valid  output  1  a key event is pending
- key_ack  input  1  consumer accepts the pending event
- key_held  output  1  a debounced key is currently down
- overrun  output  1  sticky; set when an event was lost

## Operation
- col_in passes through a 2-flop synchronizer. All decisions use the synchronized value col_s.
- Tick counter: 28-bit, counts 0..SCAN_DIV. tick=1 in the cycle when count==SCAN_DIV, then the counter wraps to 0. It free-runs in every state.
- Column decode: the pressed column is the lowest index with col_s bit low. "none" means col_s==4'b1111.
- FSM states SCAN, DEBOUNCE, PRESSED, RELEASE. All transitions happen on tick only.
  - SCAN: if column is none, advance the row (0→1→2→3→0). Otherwise lock the row, capture cand={row,col}, set cnt=1, and go to DEBOUNCE. If DEBOUNCE_SCANS==1, go directly to PRESSED and emit an event.
  - DEBOUNCE: if the decoded code equals cand, cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED and emit an event. If the code differs or is none, advance the row and go to SCAN.
  - PRESSED: key_held=1. If column is none, set cnt=1 and go to RELEASE. Otherwise stay.
  - RELEASE: key_held stays 1. If none, cnt++; when cnt reaches DEBOUNCE_SCANS, clear key_held, advance the row, and go to SCAN. If cand is seen again, return to PRESSED with no new event.
- Event emission:
  - If key_valid=0: key_code←cand and key_valid←1.
  - If key_valid=1 and key_ack=0 in the same cycle: key_code is kept, the event is dropped, and overrun←1.
  - If key_valid=1 and key_ack=1 in the same cycle: the new event wins; key_code←cand, key_valid stays 1, overrun unchanged.
- Handshake: key_ack is sampled only while key_valid=1. The cycle after an ack, key_valid=0 and overrun=0. key_ack while key_valid=0 is ignored.
- Multiple keys: only the first key found in scan order (row, then lowest column) is tracked. Other keys are ignored until return to SCAN.

## Timing
- Reset (reset=0 at a clk edge) applies in all states, including mid-debounce:
  - row_sel=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0.
  - Counter=0, row=0, FSM=SCAN, synchronizer flops=4'b1111.
- Column-to-decision latency: 2 clocks of synchronizer, plus the wait for the next tick.
- Row change appears on row_sel in the cycle after the tick. Columns are therefore sampled a full tick period after the row is driven.
- Press-to-key_valid: key_valid rises the clock after the DEBOUNCE_SCANS-th qualifying tick.
- key_valid is registered; there is no combinational path from key_ack or col_in to any output.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter counts ticks.
  - Every REPEAT_SCANS ticks it emits an event with the same cand, under the same handshake and overrun rules.
  - The counter restarts on entry to PRESSED, including re-entry from RELEASE.
- KEYPAD_REPEAT_EN undefined: the repeat counter is absent and exactly one event is emitted per debounced press.

## Structure
- Package keypad_pkg holds:
  - the FSM state typedef (SCAN, DEBOUNCE, PRESSED, RELEASE);
  - COL_NONE=4'b1111;
  - ROW_RESET=4'b1110;
  - the key-code type (4-bit).
- Sub-module sync_2ff (parameterized width, reset value 1s) holds the column synchronizer. The FSM, tick counter and handshake stay in keypad_scan.

## Test plan
Parameters for all scenarios: SCAN_DIV=3, DEBOUNCE_SCANS=2.
- Reset, then idle columns → row_sel cycles 1110, 1101, 1011, 0111 with a 4-clock dwell; key_valid stays 0.
- Hold col 2 low only while row 1 is driven → key_code=4'h6, key_valid=1 after 2 qualifying ticks. key_ack pulse → key_valid=0 on the next clock.
- 1-tick glitch on col 0 in row 3 → no event; scanning resumes at row 0.
- Two presses with no ack between them → key_code keeps the first value and overrun=1. key_ack → overrun=0 and key_valid=0.
- Ack in the same cycle as a new event → key_valid stays 1, key_code equals the new code, overrun=0.
- reset=0 asserted mid-DEBOUNCE → all outputs return to reset values on the next clk edge. With KEYPAD_REPEAT_EN and REPEAT_SCANS=3, a held key 4'hF emits a repeat event every 3 ticks.
